// File: rtl/wb_scheduler_if.sv
// wb_scheduler_if: EXE/WB lane outputs, per-lane enables/stalls and the register-file write port.
interface wb_scheduler_if #(parameter int DATA_W = 32, parameter int RD_W = 4);
  logic [3:0] exe_valid;
  logic [RD_W-1:0] alu_rd, ld_rd, mul_rd, div_rd;
  logic [DATA_W-1:0] alu_wb, ld_wb, mul_wb, div_wb;
  logic [3:0] wr_allow, exe_stall, grant;
  logic rf_we;
  logic [RD_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [7:0] stall_cnt_alu, stall_cnt_ld, stall_cnt_mul, stall_cnt_div;
  modport master (
    output exe_valid, alu_rd, ld_rd, mul_rd, div_rd, alu_wb, ld_wb, mul_wb, div_wb,
    input wr_allow, exe_stall, grant, rf_we, rf_waddr, rf_wdata,
    input stall_cnt_alu, stall_cnt_ld, stall_cnt_mul, stall_cnt_div
  );
  modport slave (
    input exe_valid, alu_rd, ld_rd, mul_rd, div_rd, alu_wb, ld_wb, mul_wb, div_wb,
    output wr_allow, exe_stall, grant, rf_we, rf_waddr, rf_wdata,
    output stall_cnt_alu, stall_cnt_ld, stall_cnt_mul, stall_cnt_div
  );
endinterface

// File: rtl/wb_scheduler.sv
// wb_scheduler: oldest-first write-back arbiter for the ALU/LD/MUL/DIV EXE/WB lanes.
// Optional stall counters are built when WB_SCHED_STATS_EN is defined.
module wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int RD_W = 4
) (
  input logic clk,
  input logic rst_n,
  wb_scheduler_if.slave io_wb
);
  logic [3:0] r_pending;
  logic [1:0] r_age [4];
  logic [RD_W-1:0] w_rd [4];
  logic [DATA_W-1:0] w_wb [4];
  logic [1:0] w_nage [4];
  logic [3:0] w_old, w_grant, w_rem, w_allow, w_cap, w_stall;
  logic w_shift;
  logic [1:0] w_top, w_cap_age;
  logic [RD_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0] w_cnt [4];
  assign w_rd[0] = io_wb.div_rd;
  assign w_rd[1] = io_wb.mul_rd;
  assign w_rd[2] = io_wb.ld_rd;
  assign w_rd[3] = io_wb.alu_rd;
  assign w_wb[0] = io_wb.div_wb;
  assign w_wb[1] = io_wb.mul_wb;
  assign w_wb[2] = io_wb.ld_wb;
  assign w_wb[3] = io_wb.alu_wb;
  // Ages stay dense from 0, so the oldest group is always rank 0; lowest index wins ties.
  always_comb begin
    w_old = '0;
    for (int k = 0; k < 4; k++) w_old[k] = r_pending[k] & (r_age[k] == 2'd0);
  end
  assign w_grant = w_old & (~w_old + 4'd1);
  assign w_rem = r_pending & ~w_grant;
  assign w_shift = ~|(w_rem & w_old);
  assign w_allow = ~r_pending | w_grant;
  assign w_cap = io_wb.exe_valid & w_allow;
  assign w_stall = io_wb.exe_valid & ~w_allow;
  always_comb begin
    w_top = '0;
    w_waddr = '0;
    w_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      w_nage[k] = r_age[k] - {1'b0, w_shift};
      if (w_rem[k] && w_nage[k] > w_top) w_top = w_nage[k];
      if (w_grant[k]) begin
        w_waddr = w_rd[k];
        w_wdata = w_wb[k];
      end
    end
  end
  assign w_cap_age = |w_rem ? w_top + 2'd1 : 2'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      for (int k = 0; k < 4; k++) r_age[k] <= '0;
    end else begin
      r_pending <= w_rem | w_cap;
      for (int k = 0; k < 4; k++) r_age[k] <= w_cap[k] ? w_cap_age : w_rem[k] ? w_nage[k] : 2'd0;
    end
  end
`ifdef WB_SCHED_STATS_EN
  logic [7:0] r_cnt [4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) if (w_stall[k] && r_cnt[k] != 8'hFF) r_cnt[k] <= r_cnt[k] + 8'd1;
    end
  end
  assign w_cnt = r_cnt;
`else
  assign w_cnt = '{default: 8'd0};
`endif
  assign io_wb.wr_allow = w_allow;
  assign io_wb.exe_stall = w_stall;
  assign io_wb.grant = w_grant;
  assign io_wb.rf_we = |r_pending;
  assign io_wb.rf_waddr = w_waddr;
  assign io_wb.rf_wdata = w_wdata;
  assign io_wb.stall_cnt_div = w_cnt[0];
  assign io_wb.stall_cnt_mul = w_cnt[1];
  assign io_wb.stall_cnt_ld = w_cnt[2];
  assign io_wb.stall_cnt_alu = w_cnt[3];
endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Write-back scheduler for the four-lane EXE/WB stage (ALU, LD, MUL, DIV). Tracks which EXE/WB lanes hold an unwritten result, grants the single register-file write port to the oldest pending lane, and drives the per-lane `wr_allow` enables of the EXE/WB pipeline register. Lanes that cannot be freed are reported as stalls to the issue logic. Sits between the EXE/WB register outputs and the register-file write port.

## Interface
- `DATA_W`, 32, result data width.
- `RD_W`, 4, destination register index width.
- `clk  in  1  single clock; all state updates on rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `exe_valid  in  4  lane result valid in EXE this cycle; bit 3 ALU, 2 LD, 1 MUL, 0 DIV`
- `alu_rd, ld_rd, mul_rd, div_rd  in  RD_W  EXE/WB register Rd outputs per lane`
- `alu_wb, ld_wb, mul_wb, div_wb  in  DATA_W  EXE/WB register data outputs per lane`
- `wr_allow  out  4  per-lane load enable to EXE/WB register, same bit order`
- `exe_stall  out  4  lane has valid result but cannot be captured this cycle`
- `rf_we  out  1  register-file write enable`
- `rf_waddr  out  RD_W  write address`
- `rf_wdata  out  DATA_W  write data`
- `grant  out  4  one-hot lane being written this cycle (0 when idle)`
- `stall_cnt_alu, stall_cnt_ld, stall_cnt_mul, stall_cnt_div  out  8  per-lane stall counters (see Configuration)`

## Operation
- Per-lane state: `pending[i]` (lane holds unwritten result) and 2-bit age `age[i]` (capture order rank among pending lanes).
- Capture: at edge, if `exe_valid[i] & wr_allow[i]`, `pending[i]` is set; lane receives age rank younger than every lane already pending.
- Arbitration (combinational from state): among pending lanes, grant the oldest. Lanes captured in the same edge share age; tie broken by fixed priority DIV > MUL > LD > ALU.
- Write: `rf_we = |pending`; `rf_waddr/rf_wdata` muxed from granted lane's `*_rd/*_wb`; `grant` one-hot of that lane.
- Release: at edge, the granted lane clears `pending` unless recaptured in the same edge (then it stays pending, ranked youngest).
- After release, remaining pending lanes keep relative order; ranks compress so oldest is 0.
- `wr_allow[i] = ~pending[i] | grant[i]` — a lane is reloadable when empty or being drained this cycle.
- `exe_stall[i] = exe_valid[i] & ~wr_allow[i]`.
- WAW: two pending lanes with same Rd are written oldest first; the younger value is final. Same-edge captures to the same Rd resolve by tie priority (higher-priority lane written first, lower-priority value final).
- At most one RF write per cycle; throughput one result per cycle aggregate.

## Timing
- Reset (async, `rst_n` low): `pending=0`, all ages 0, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `grant=0`, `wr_allow=4'b1111`, `exe_stall=0`, counters 0. Outputs take reset values immediately, independent of `clk`.
- Reset mid-operation discards all pending results; no write issued for them.
- Latency: result captured at edge N appears on `rf_*` in cycle N..N+1 when no older lane pending; written to RF at edge N+1.
- Worst case: four lanes captured same edge → written over four consecutive cycles in tie-priority order; each lane's `wr_allow` returns high in its grant cycle.
- Simultaneous grant and recapture on one lane: no bubble; lane writes old value this cycle and holds new value next.
- Idle (no pending): `rf_we=0`, `rf_waddr`/`rf_wdata` held at 0, `grant=0`.

## Configuration
- `WB_SCHED_STATS_EN` defined: each `stall_cnt_*` increments by 1 on every edge where the corresponding `exe_stall` bit is high; saturates at 255; cleared only by reset.
- Not defined: counter logic is not built; `stall_cnt_*` outputs tied to 0.

## Test plan
- Reset: hold `rst_n` low with `exe_valid=4'b1111` → `wr_allow=4'b1111`, `rf_we=0`, `grant=0`, `exe_stall=0`; release and clock → normal capture resumes.
- Single lane: ALU captures Rd=3, data 0x0000_00AA → next cycle `rf_we=1`, `rf_waddr=3`, `rf_wdata=0xAA`, `grant=4'b1000`; following cycle idle.
- Four-way collision: all lanes valid on one edge → grants DIV, MUL, LD, ALU on four consecutive cycles; `exe_stall` on lanes still pending when re-presented valid.
- Age ordering: ALU captures at edge 1 while DIV is pending from edge 0, then LD at edge 2 → writes ordered DIV, ALU, LD regardless of fixed priority.
- WAW: MUL captures Rd=5 = 0x11 at edge 0, ALU captures Rd=5 = 0x22 at edge 1 → RF sees 0x11 then 0x22; final R5 = 0x22.
- Stats (`WB_SCHED_STATS_EN`): hold LD stalled for 300 cycles → `stall_cnt_ld=255`; without macro → all counters 0.
